// File: rtl/opl3_reg_arbiter.sv
// ============================================================================
// Module   : opl3_reg_arbiter
// Purpose  : Two-requester round-robin arbiter (host / sequencer) that feeds
//            single-cycle OPL3 register write pulses with a minimum spacing.
// Options  : define OPL3_REG_ARB_GAP_EN to compile in the GAP state/counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module opl3_reg_arbiter #(
  parameter int MIN_GAP = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_valid,
  input  logic [16:0] host_wr,
  output logic        host_ready,
  input  logic        seq_valid,
  input  logic [16:0] seq_wr,
  output logic        seq_ready,
  input  logic        seq_lock,
  output logic [17:0] opl3_reg_wr,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  if (MIN_GAP < 2 || MIN_GAP > 255) begin : g_min_gap_range
    $error("opl3_reg_arbiter: MIN_GAP must be within 2..255");
  end

  state_t      r_state;
  logic        r_last_seq;
  logic [17:0] r_wr;

  logic        w_idle;
  logic        w_seq_win;
  logic        w_host_win;
  logic        w_xfer;
  logic [16:0] w_payload;

  // Seq wins when alone, when host had the last grant, or when it holds a lock.
  assign w_seq_win  = seq_valid & (~host_valid | ~r_last_seq | seq_lock);
  assign w_host_win = host_valid & ~w_seq_win;
  assign w_idle     = (r_state == S_IDLE) & ~reset;
  assign w_xfer     = w_idle & (w_seq_win | w_host_win);
  assign w_payload  = w_seq_win ? seq_wr : host_wr;

  assign host_ready  = w_idle & w_host_win;
  assign seq_ready   = w_idle & w_seq_win;
  assign opl3_reg_wr = r_wr;
  assign busy        = (r_state != S_IDLE);

`ifdef OPL3_REG_ARB_GAP_EN
  // ISSUE is cycle t+1, GAP spans t+2 .. t+MIN_GAP-1, so it lasts MIN_GAP-2 cycles.
  localparam logic [7:0] C_GAP_LOAD = (MIN_GAP > 2) ? 8'(MIN_GAP - 3) : 8'd0;
  logic [7:0] r_gap_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr       <= '0;
      r_last_seq <= 1'b1;
      r_gap_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_state    <= S_ISSUE;
            r_wr       <= {1'b1, w_payload};
            r_last_seq <= w_seq_win;
          end
        end
        S_ISSUE: begin
          r_wr[17] <= 1'b0;
          if (MIN_GAP > 2) begin
            r_state   <= S_GAP;
            r_gap_cnt <= C_GAP_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 8'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr       <= '0;
      r_last_seq <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_state    <= S_ISSUE;
            r_wr       <= {1'b1, w_payload};
            r_last_seq <= w_seq_win;
          end
        end
        S_ISSUE: begin
          r_wr[17] <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_opl3_reg_arbiter.sv
// ============================================================================
// Module   : tb_opl3_reg_arbiter
// Purpose  : Directed self-checking bench for opl3_reg_arbiter (either build of
//            OPL3_REG_ARB_GAP_EN).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_opl3_reg_arbiter;

  localparam int C_MIN_GAP = 32;
`ifdef OPL3_REG_ARB_GAP_EN
  localparam int C_SP       = C_MIN_GAP;
  localparam int C_RST_WAIT = 6;
`else
  localparam int C_SP       = 2;
  localparam int C_RST_WAIT = 0;
`endif
  localparam logic [16:0] C_HP  = 17'h1B02A;
  localparam logic [16:0] C_SPL = 17'h04055;
  localparam logic [16:0] C_HP2 = 17'h0A53C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        host_valid = 1'b0;
  logic [16:0] host_wr = '0;
  logic        host_ready;
  logic        seq_valid = 1'b0;
  logic [16:0] seq_wr = '0;
  logic        seq_ready;
  logic        seq_lock = 1'b0;
  logic [17:0] opl3_reg_wr;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int q_cyc[$];
  logic [16:0] q_pay[$];

  opl3_reg_arbiter #(.MIN_GAP(C_MIN_GAP)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .host_valid  (host_valid),
    .host_wr     (host_wr),
    .host_ready  (host_ready),
    .seq_valid   (seq_valid),
    .seq_wr      (seq_wr),
    .seq_ready   (seq_ready),
    .seq_lock    (seq_lock),
    .opl3_reg_wr (opl3_reg_wr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (opl3_reg_wr[17]) begin
      q_cyc.push_back(cyc);
      q_pay.push_back(opl3_reg_wr[16:0]);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_issues(input int n, input string tag);
    int budget;
    budget = 6 * C_SP + 20;
    while (q_pay.size() < n && budget > 0) begin
      step();
      budget--;
    end
    if (q_pay.size() < n) check_val({tag, "_timeout"}, q_pay.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 2 * C_SP + 10;
    while (busy && budget > 0) begin
      step();
      budget--;
    end
    if (busy) check_val({tag, "_idle_timeout"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    host_valid = 1'b0;
    seq_valid  = 1'b0;
    seq_lock   = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    int base;
    int bad;
    int budget;

    // Reset state, with both requesters asserting valid.
    host_wr = C_HP;
    seq_wr  = C_SPL;
    step();
    host_valid = 1'b1;
    seq_valid  = 1'b1;
    #1;
    check_val("rst_wr", opl3_reg_wr, 18'h0);
    check_val("rst_busy", busy, 0);
    check_val("rst_host_ready", host_ready, 0);
    check_val("rst_seq_ready", seq_ready, 0);
    host_valid = 1'b0;
    seq_valid  = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Single host write after reset.
    host_wr    = C_HP;
    host_valid = 1'b1;
    #1;
    check_val("t1_host_ready", host_ready, 1);
    check_val("t1_seq_ready", seq_ready, 0);
    step();
    host_valid = 1'b0;
    check_val("t1_issue", opl3_reg_wr, 18'h3B02A);
    check_val("t1_busy", busy, 1);
    step();
    check_val("t1_hold", opl3_reg_wr, 18'h1B02A);
    wait_idle("t1");

    // Continuous contention: host, seq, host at C_SP spacing.
    do_reset();
    base = q_pay.size();
    host_wr = C_HP;
    seq_wr  = C_SPL;
    host_valid = 1'b1;
    seq_valid  = 1'b1;
    wait_issues(base + 3, "rr");
    host_valid = 1'b0;
    seq_valid  = 1'b0;
    wait_idle("rr");
    if (q_pay.size() >= base + 3) begin
      check_val("rr_own0", q_pay[base],     C_HP);
      check_val("rr_own1", q_pay[base + 1], C_SPL);
      check_val("rr_own2", q_pay[base + 2], C_HP);
      check_val("rr_gap01", q_cyc[base + 1] - q_cyc[base],     C_SP);
      check_val("rr_gap12", q_cyc[base + 2] - q_cyc[base + 1], C_SP);
    end

    // Seq lock keeps ownership, release hands over to host.
    do_reset();
    base = q_pay.size();
    seq_valid = 1'b1;
    wait_issues(base + 1, "lk_first");
    host_valid = 1'b1;
    seq_lock   = 1'b1;
    wait_issues(base + 4, "lk_burst");
    seq_lock = 1'b0;
    wait_issues(base + 5, "lk_release");
    host_valid = 1'b0;
    seq_valid  = 1'b0;
    wait_idle("lk");
    if (q_pay.size() >= base + 5) begin
      for (int i = 0; i < 4; i++) check_val($sformatf("lk_seq%0d", i), q_pay[base + i], C_SPL);
      check_val("lk_host", q_pay[base + 4], C_HP);
    end

    // Reset part-way through the post-issue window.
    do_reset();
    base = q_pay.size();
    host_valid = 1'b1;
    wait_issues(base + 1, "ra");
    host_valid = 1'b0;
    repeat (C_RST_WAIT) step();
    check_val("ra_busy_before", busy, 1);
    reset      = 1'b1;
    host_valid = 1'b1;
    seq_valid  = 1'b1;
    #1;
    check_val("ra_busy", busy, 0);
    check_val("ra_wr", opl3_reg_wr, 18'h0);
    check_val("ra_ready", {host_ready, seq_ready}, 2'b00);
    step();
    reset = 1'b0;
    #1;
    check_val("ra_host_wins", {host_ready, seq_ready}, 2'b10);
    base = q_pay.size();
    wait_issues(base + 1, "ra_post");
    host_valid = 1'b0;
    seq_valid  = 1'b0;
    if (q_pay.size() >= base + 1) check_val("ra_post_pay", q_pay[base], C_HP);
    wait_idle("ra");

    // Host raised while the arbiter is busy waits for IDLE.
    base = q_pay.size();
    seq_valid = 1'b1;
    wait_issues(base + 1, "hw");
    seq_valid  = 1'b0;
    host_wr    = C_HP2;
    host_valid = 1'b1;
    #1;
    bad = 0;
    budget = 2 * C_SP + 10;
    while (busy && budget > 0) begin
      if (host_ready) bad++;
      step();
      budget--;
    end
    check_val("hw_ready_while_busy", bad, 0);
    check_val("hw_ready_at_idle", host_ready, 1);
    wait_issues(base + 2, "hw_issue");
    host_valid = 1'b0;
    if (q_pay.size() >= base + 2) begin
      check_val("hw_pay", q_pay[base + 1], C_HP2);
      check_val("hw_spacing", q_cyc[base + 1] - q_cyc[base], C_SP);
    end
    wait_idle("hw");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
